// File: rtl/bmm_pkg.sv
// -----------------------------------------------------------------------------
// bmm_pkg
// Shared definitions for the instruction fetch front end.
//   fetch_state_t      : fetch control FSM states (BOOT, RUN, FLUSH)
//   INSTR_WIDTH        : instruction and address width in bits
//   BOOT_ADDR_DEFAULT  : default PC after reset
//   word_align()       : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package bmm_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    function automatic logic [INSTR_WIDTH-1:0] word_align(input logic [INSTR_WIDTH-1:0] a);
        return a & ~(INSTR_WIDTH'(3));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with a single-cycle flush. Used both as the instruction
// buffer ({pc, instr}) and as the queue of PCs whose fetches are in flight.
//
// Ports:
//   clk_i    in   clock (rising edge)
//   rst_i    in   asynchronous active-high reset
//   flush_i  in   empties the FIFO; push/pop in the same cycle are ignored
//   push_i   in   write data_i at the tail (ignored when full)
//   data_i   in   WIDTH-bit write data
//   pop_i    in   remove the head entry (ignored when empty)
//   data_o   out  head entry, zero while empty
//   empty_o  out  no entries
//   full_o   out  DEPTH entries
//   count_o  out  number of entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import bmm_pkg::*;
#(
    parameter int WIDTH = INSTR_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign count_o = r_count;

    assign w_push = push_i & ~full_o  & ~flush_i;
    assign w_pop  = pop_i  & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Masking the head keeps the output at zero while nothing valid is held.
    assign data_o = empty_o ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: generates the sequential PC, issues word-aligned
// requests to instruction memory under a credit limit, buffers returned
// instructions with their PCs and presents them to decode. A redirect from the
// branch unit squashes buffered instructions and discards responses to
// requests already in flight.
//
// Ports:
//   clk_i             in   clock (rising edge)
//   rst_i             in   asynchronous active-high reset
//   redirect_valid_i  in   single-cycle redirect pulse
//   redirect_addr_i   in   redirect target (bits [1:0] ignored)
//   imem_req_valid_o  out  fetch request valid
//   imem_req_ready_i  in   memory accepts the request
//   imem_req_addr_o   out  fetch address (current PC)
//   imem_rsp_valid_i  in   in-order response valid (always accepted)
//   imem_rsp_data_i   in   instruction word
//   instr_valid_o     out  instruction available to decode
//   instr_ready_i     in   decode accepts the instruction
//   instr_o           out  instruction at the buffer head
//   instr_pc_o        out  PC of instr_o
// -----------------------------------------------------------------------------
module fetch_unit
    import bmm_pkg::*;
#(
    parameter logic [INSTR_WIDTH-1:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
    parameter int                     FIFO_DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   redirect_valid_i,
    input  logic [INSTR_WIDTH-1:0] redirect_addr_i,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [INSTR_WIDTH-1:0] imem_req_addr_o,
    input  logic                   imem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [INSTR_WIDTH-1:0] instr_pc_o
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = CNT_W + 1;
    localparam int PAIR_W = 2 * INSTR_WIDTH;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [INSTR_WIDTH-1:0] r_pc;
    logic [CNT_W-1:0]       r_outstanding;
    logic [CNT_W-1:0]       r_discard;

    logic                   w_redirect;
    logic                   w_credit;
    logic                   w_req_fire;
    logic                   w_rsp_any;
    logic                   w_rsp_keep;
    logic                   w_instr_pop;
    logic [CNT_W-1:0]       w_discard_new;

    logic [PAIR_W-1:0]      w_ififo_head;
    logic                   w_ififo_empty;
    logic                   w_ififo_full;
    logic [CNT_W-1:0]       w_fifo_count;

    logic [INSTR_WIDTH-1:0] w_pcq_head;
    logic                   w_pcq_empty;
    logic                   w_pcq_full;
    logic [CNT_W-1:0]       w_pcq_count;

    logic                   w_unused_bits;

    // A redirect is ignored in BOOT; the PC is still being loaded.
    assign w_redirect = redirect_valid_i & (r_state != BOOT);

    // Credit: every request must have a guaranteed slot in the instruction
    // buffer when its response returns, so in-flight plus buffered is capped.
    assign w_credit = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < SUM_W'(FIFO_DEPTH);

    assign imem_req_valid_o = (r_state == RUN) & ~redirect_valid_i & w_credit;
    assign imem_req_addr_o  = r_pc;
    assign w_req_fire       = imem_req_valid_o & imem_req_ready_i;

    // Any response retires one outstanding request; the guard only protects
    // the counter from a spurious response that has no matching request.
    assign w_rsp_any  = imem_rsp_valid_i & (r_state != BOOT) & (r_outstanding != '0);

    // Only responses for current-path requests are kept; one that lands in a
    // redirect cycle belongs to the old path.
    assign w_rsp_keep = w_rsp_any & (r_state == RUN) & ~redirect_valid_i;

    assign w_discard_new = r_outstanding - CNT_W'(w_rsp_any);

    assign instr_valid_o = ~w_ififo_empty & ~redirect_valid_i;
    assign w_instr_pop   = instr_valid_o & instr_ready_i;

    assign instr_pc_o = w_ififo_head[PAIR_W-1:INSTR_WIDTH];
    assign instr_o    = w_ififo_head[INSTR_WIDTH-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (redirect_valid_i) begin
                    w_state_nxt = (w_discard_new != '0) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (redirect_valid_i) begin
                    w_state_nxt = (w_discard_new != '0) ? FLUSH : RUN;
                end else if (w_rsp_any && (r_discard <= CNT_W'(1))) begin
                    // Last wrong-path response drains this cycle.
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // ---------------- PC and counters ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc          <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            if (w_redirect) begin
                r_pc <= word_align(redirect_addr_i);
            end else if (w_req_fire) begin
                r_pc <= r_pc + INSTR_WIDTH'(4);
            end

            r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_any);

            if (w_redirect) begin
                r_discard <= w_discard_new;
            end else if ((r_state == FLUSH) && w_rsp_any && (r_discard != '0)) begin
                r_discard <= r_discard - CNT_W'(1);
            end
        end
    end

    // ---------------- buffers ----------------
    // PC of each accepted request, popped in order as its response returns.
    fetch_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_pc_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (w_redirect),
        .push_i  (w_req_fire),
        .data_i  (r_pc),
        .pop_i   (w_rsp_keep),
        .data_o  (w_pcq_head),
        .empty_o (w_pcq_empty),
        .full_o  (w_pcq_full),
        .count_o (w_pcq_count)
    );

    fetch_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_instr_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (w_redirect),
        .push_i  (w_rsp_keep),
        .data_i  ({w_pcq_head, imem_rsp_data_i}),
        .pop_i   (w_instr_pop),
        .data_o  (w_ififo_head),
        .empty_o (w_ififo_empty),
        .full_o  (w_ififo_full),
        .count_o (w_fifo_count)
    );

    // Status bits the credit scheme makes redundant, plus ignored offset bits.
    assign w_unused_bits = ^{w_pcq_empty, w_pcq_full, w_pcq_count, w_ififo_full,
                             redirect_addr_i[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] TB_BOOT  = 32'h0000_0100;
    localparam int          TB_DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_addr_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    fetch_unit #(
        .BOOT_ADDR  (TB_BOOT),
        .FIFO_DEPTH (TB_DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_addr_i  (redirect_addr_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          rst_first;
        bit          ir;
        logic        ev;
        logic [31:0] ea;
        logic        eiv;
        logic [31:0] epc;
    } vec_t;

    mreq_t       mq[$];
    exp_t        exp_q[$];
    logic [31:0] exp_pc;
    int          cyc  = 0;
    int          lat  = 1;
    int          nvec = 0;
    int          nerr = 0;
    int          ndec = 0;
    vec_t        tbl[18];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive the memory response for this cycle, let outputs settle, then run
    // the scoreboard on the handshakes that will complete at the next edge.
    task automatic settle();
        exp_t e;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
        end
        #1;
        if (redirect_valid_i) begin
            chk("redir_req_gated", 32'(imem_req_valid_o), 32'd0);
            chk("redir_instr_gated", 32'(instr_valid_o), 32'd0);
            exp_q.delete();
            exp_pc = {redirect_addr_i[31:2], 2'b00};
        end
        if (imem_req_valid_o && imem_req_ready_i) begin
            chk("req_addr", imem_req_addr_o, exp_pc);
            chk("req_credit", 32'(exp_q.size() < TB_DEPTH), 32'd1);
            e.pc   = imem_req_addr_o;
            e.data = mem_word(imem_req_addr_o);
            exp_q.push_back(e);
            mq.push_back('{addr: imem_req_addr_o, due: cyc + lat});
            exp_pc = exp_pc + 32'd4;
        end
        if (instr_valid_o && instr_ready_i) begin
            ndec++;
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL dec_unexpected: got pc %h, expected no instruction (cycle %0d)",
                         instr_pc_o, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("dec_pc", instr_pc_o, e.pc);
                chk("dec_instr", instr_o, e.data);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic expect_out(input string name, input logic rv, input logic [31:0] ra,
                              input logic iv);
        chk({name, "_req_valid"}, 32'(imem_req_valid_o), 32'(rv));
        if (rv) chk({name, "_req_addr"}, imem_req_addr_o, ra);
        chk({name, "_instr_valid"}, 32'(instr_valid_o), 32'(iv));
    endtask

    // Asserted just after a falling edge: the asynchronous reset must clear
    // the outputs without waiting for a clock edge.
    task automatic do_reset();
        rst_i            = 1'b1;
        redirect_valid_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        mq.delete();
        exp_q.delete();
        exp_pc = TB_BOOT;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_req_addr", imem_req_addr_o, TB_BOOT);
        chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_instr_pc", instr_pc_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        int d0;

        // Boot with single-cycle memory, then back-pressure from decode.
        // Fields: rst_first, instr_ready, req_valid, req_addr, instr_valid, instr_pc
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h10C, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h110, 1'b1, 32'h108};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h10C};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 32'h10C, 1'b0, 32'h0};

        rst_i            = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_addr_i  = 32'h0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        instr_ready_i    = 1'b1;
        repeat (2) @(negedge clk_i);

        lat = 1;
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst_first) do_reset();
            instr_ready_i    = tbl[i].ir;
            imem_req_ready_i = 1'b1;
            settle();
            chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid_o), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_req_addr", i), imem_req_addr_o, tbl[i].ea);
            chk($sformatf("tbl%0d_instr_valid", i), 32'(instr_valid_o), 32'(tbl[i].eiv));
            if (tbl[i].eiv) chk($sformatf("tbl%0d_instr_pc", i), instr_pc_o, tbl[i].epc);
            advance();
        end

        // Redirect with nothing in flight while the buffer holds two entries.
        do_reset();
        lat = 1;
        instr_ready_i = 1'b0;
        repeat (6) cycle();
        redirect_valid_i = 1'b1;
        redirect_addr_i  = 32'h0000_0203;
        cycle();
        redirect_valid_i = 1'b0;
        settle();
        expect_out("C_next", 1'b1, 32'h200, 1'b0);
        advance();
        instr_ready_i = 1'b1;
        d0 = ndec;
        repeat (8) cycle();
        chk("C_progress", 32'(ndec > d0), 32'd1);

        // Redirect with two responses in flight.
        do_reset();
        lat = 3;
        instr_ready_i = 1'b1;
        repeat (3) cycle();
        redirect_valid_i = 1'b1;
        redirect_addr_i  = 32'h0000_0300;
        cycle();
        redirect_valid_i = 1'b0;
        settle(); expect_out("D_flush1", 1'b0, 32'h0, 1'b0); advance();
        settle(); expect_out("D_flush2", 1'b0, 32'h0, 1'b0); advance();
        settle(); expect_out("D_resume", 1'b1, 32'h300, 1'b0); advance();
        d0 = ndec;
        repeat (10) cycle();
        chk("D_progress", 32'(ndec > d0), 32'd1);

        // Redirect in the same cycle as the only outstanding response.
        do_reset();
        lat = 1;
        repeat (2) cycle();
        redirect_valid_i = 1'b1;
        redirect_addr_i  = 32'h0000_0400;
        cycle();
        redirect_valid_i = 1'b0;
        settle(); expect_out("E_next", 1'b1, 32'h400, 1'b0); advance();
        settle(); chk("E_no_stale", 32'(instr_valid_o), 32'd0); advance();
        d0 = ndec;
        repeat (6) cycle();
        chk("E_progress", 32'(ndec > d0), 32'd1);

        // Second redirect while flushing: the later target wins.
        do_reset();
        lat = 3;
        repeat (3) cycle();
        redirect_valid_i = 1'b1;
        redirect_addr_i  = 32'h0000_0500;
        cycle();
        redirect_addr_i  = 32'h0000_0600;
        cycle();
        redirect_valid_i = 1'b0;
        settle(); expect_out("F_flush", 1'b0, 32'h0, 1'b0); advance();
        settle(); expect_out("F_resume", 1'b1, 32'h600, 1'b0); advance();
        repeat (8) cycle();

        // PC wrap past the top of the address space.
        do_reset();
        lat = 1;
        cycle();
        redirect_valid_i = 1'b1;
        redirect_addr_i  = 32'hFFFF_FFFF;
        cycle();
        redirect_valid_i = 1'b0;
        settle(); expect_out("W_top", 1'b1, 32'hFFFF_FFFC, 1'b0); advance();
        settle(); expect_out("W_wrap", 1'b1, 32'h0000_0000, 1'b0); advance();
        repeat (6) cycle();

        // Random traffic for each memory latency.
        for (int l = 1; l <= 3; l++) begin
            do_reset();
            lat = l;
            instr_ready_i    = 1'b1;
            imem_req_ready_i = 1'b1;
            cycle();
            d0 = ndec;
            for (int k = 0; k < 200; k++) begin
                instr_ready_i    = ($urandom_range(0, 3) != 0);
                imem_req_ready_i = ($urandom_range(0, 3) != 0);
                redirect_valid_i = ($urandom_range(0, 15) == 0);
                redirect_addr_i  = $urandom;
                cycle();
            end
            redirect_valid_i = 1'b0;
            chk($sformatf("rand_lat%0d_progress", l), 32'(ndec > d0), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that generates the sequential PC, issues word-aligned requests to instruction memory, buffers returned instructions with their PCs, and hands them to decode through a valid/ready interface. It sits upstream of decode and takes its redirect from the execute-stage branch unit (`jump_addr_o` qualified by `mispredict_o | instr_jump_o`). It squashes wrong-path instructions held locally and in flight to memory.

## Interface
Parameters:
- `BOOT_ADDR`, default 32'h0000_0000 — PC after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2 — instruction buffer entries; also the cap on requests in flight; must be ≥1.

Ports:
- `clk_i`  in  1  clock. This block uses one clock, and all state updates on its rising edge.
- `rst_i`  in  1  reset. Reset is asynchronous and active-high.
- `redirect_valid_i`  in  1  redirect from the branch unit, single-cycle pulse.
- `redirect_addr_i`  in  32  redirect target. Bits [1:0] are ignored and forced to 0.
- `imem_req_valid_o`  out  1  fetch request valid.
- `imem_req_ready_i`  in  1  memory accepts the request.
- `imem_req_addr_o`  out  32  fetch address, equal to `pc_q`.
- `imem_rsp_valid_i`  in  1  response valid. Responses return in request order and are always accepted.
- `imem_rsp_data_i`  in  32  instruction word.
- `instr_valid_o`  out  1  buffered instruction available to decode.
- `instr_ready_i`  in  1  decode accepts the instruction.
- `instr_o`  out  32  instruction at the FIFO head.
- `instr_pc_o`  out  32  PC of `instr_o`.

## Operation
- **State machine** (`fetch_state_t`): `BOOT`, `RUN`, `FLUSH`.
  - Reset enters `BOOT`.
  - `BOOT` → `RUN` unconditionally on the next cycle.
- **Request issue.**
  - `imem_req_valid_o` = (state==`RUN`) & !redirect_valid_i & (outstanding + fifo_count < FIFO_DEPTH).
  - On `imem_req_valid_o & imem_req_ready_i`: `pc_q += 4` (wraps modulo 2^32), `outstanding++`, and `pc_q` is pushed onto the in-flight PC queue.
  - Memory tolerates request withdrawal. A pending, unaccepted request may drop when a redirect arrives.
- **Response.**
  - On `imem_rsp_valid_i` in `RUN`: `outstanding--`, pop the PC queue, and push {pc, data} into the instruction FIFO.
  - The credit rule above guarantees the FIFO is never full at this point.
- **Redirect** (`redirect_valid_i`, any state other than `BOOT`):
  - `pc_q` ← {redirect_addr_i[31:2], 2'b00}.
  - The instruction FIFO and the PC queue are cleared.
  - `discard` ← outstanding − (imem_rsp_valid_i ? 1 : 0). A response arriving in the redirect cycle is dropped.
  - Next state: `FLUSH` if the new `discard` > 0, else `RUN`.
- **`FLUSH` state.**
  - No requests are issued.
  - Each response decrements both `discard` and `outstanding`, and its data is dropped.
  - When `discard` reaches 0 (including the decrement in that cycle), go to `RUN`.
  - A further redirect in `FLUSH` overwrites `pc_q` and recomputes `discard` by the same rule.
- **Output.**
  - `instr_valid_o` = fifo_not_empty & !redirect_valid_i.
  - Pop on `instr_valid_o & instr_ready_i`.
  - FIFO push and pop in the same cycle are both honoured.
- **Counter widths.** `outstanding`, `discard` and `fifo_count` are each $clog2(FIFO_DEPTH+1) bits and never exceed FIFO_DEPTH.

## Timing
- **Reset values:**
  - `imem_req_valid_o`=0, `imem_req_addr_o`=BOOT_ADDR, `instr_valid_o`=0.
  - `instr_o`=0, `instr_pc_o`=0.
  - FIFO empty, outstanding=0, discard=0.
- **Reset mid-operation.** All state is cleared immediately. Responses arriving later to pre-reset requests are a system error and are not handled.
- **First request.** `imem_req_valid_o` rises in the first cycle after reset deassertion plus `BOOT`, i.e. the 2nd rising edge after release.
- **Response-to-decode latency.** A response at edge M is visible on `instr_valid_o` after edge M. There is no combinational bypass from `imem_rsp_*` to `instr_*`.
- **Redirect latency.** A redirect sampled at edge N with outstanding=0 gives a request to the target in cycle N+1.
- **Back-pressure.** With `instr_ready_i`=0, at most FIFO_DEPTH instructions are requested, after which `imem_req_valid_o` stays low.
- **Output paths.** `instr_valid_o` and `imem_req_valid_o` depend combinationally on `redirect_valid_i` only; all other outputs are registered.

## Structure
- Shared package `bmm_pkg`:
  - `fetch_state_t` enum.
  - `INSTR_WIDTH`=32.
  - `BOOT_ADDR_DEFAULT`.
- Sub-module `fetch_fifo`: a synchronous FIFO parameterised by width and depth, with a `flush_i` input.
  - One instance stores {pc, instr}.
  - A second instance serves as the in-flight PC queue.
- `fetch_unit` holds the FSM, `pc_q`, the outstanding/discard counters and the credit logic.

## Test plan
- **Reset and boot.** Release reset with BOOT_ADDR=0x100, ready=1, single-cycle memory → requests 0x100, 0x104, 0x108…, and decode sees the matching PCs in order.
- **Back-pressure.** Hold `instr_ready_i`=0 → exactly 2 requests are issued and `imem_req_valid_o` stays low. Raise ready → resumes at 0x108.
- **Redirect with nothing in flight.** Redirect to 0x203 with outstanding=0 → next-cycle request address is 0x200, and FIFO contents are dropped.
- **Redirect with in-flight responses.** Redirect with 2 responses in flight → state is `FLUSH`; both responses are discarded and none reach decode; the first request after is the target.
- **Redirect coincident with a response.** Redirect in the same cycle as a response, with outstanding=1 → that response is dropped, discard=0, and the target request issues the next cycle.
- **Redirect during `FLUSH` and PC wrap.** Second redirect while in `FLUSH` → the final target wins. Separately, PC 0xFFFF_FFFC followed by a sequential fetch → 0x0000_0000.
